// File: rtl/i2s_tx.sv
// I2S (Philips timing) transmitter: 32-bit slots, 64 BCLKs per frame, one-pair holding register.
// Optional I2S_TX_REPEAT_EN: an underrun frame resends the last loaded pair instead of zeros.
module i2s_tx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DATA_SIZE = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] s_left,
  input  logic [DATA_SIZE-1:0] s_right,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [15:0]          underrun_count
);

  localparam int unsigned     DivW    = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0]      div_q;
  logic [5:0]           pos_q;
  logic                 bclk_q;
  logic                 ws_q;
  logic                 sd_q;
  logic                 hold_empty_q;
  logic                 consumed_q;
  logic                 frame_start_q;
  logic                 underrun_q;
  logic [15:0]          ucnt_q;
  logic [DATA_SIZE-1:0] hold_l_q;
  logic [DATA_SIZE-1:0] hold_r_q;
  logic [63:0]          shift_q;

  logic        div_wrap;
  logic        fall;
  logic        accept;
  logic [5:0]  pos_next;
  logic [31:0] slot_l;
  logic [31:0] slot_r;
  logic [63:0] hold_frame;
  logic [63:0] empty_frame;

  assign div_wrap = (div_q == DivLast);
  assign fall     = div_wrap & bclk_q;
  assign accept   = s_valid & hold_empty_q;
  assign pos_next = pos_q + 6'd1;

  // Left-justify each sample in its 32-bit slot; unused LSBs stay zero.
  always_comb begin
    slot_l = '0;
    slot_r = '0;
    slot_l[31 -: DATA_SIZE] = hold_l_q;
    slot_r[31 -: DATA_SIZE] = hold_r_q;
  end

  assign hold_frame = {slot_l, slot_r};

`ifdef I2S_TX_REPEAT_EN
  logic [63:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (fall && pos_q == 6'd63 && !hold_empty_q) begin
      last_q <= hold_frame;
    end
  end

  assign empty_frame = last_q;
`else
  assign empty_frame = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      pos_q         <= 6'd63;
      bclk_q        <= 1'b0;
      ws_q          <= 1'b1;
      sd_q          <= 1'b0;
      hold_empty_q  <= 1'b1;
      consumed_q    <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucnt_q        <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      shift_q       <= '0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      consumed_q    <= 1'b0;
      div_q         <= div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap) begin
        bclk_q <= ~bclk_q;
      end

      // The holding register frees one cycle after the load that consumed it.
      if (consumed_q) begin
        hold_empty_q <= 1'b1;
      end
      if (accept) begin
        hold_l_q     <= s_left;
        hold_r_q     <= s_right;
        hold_empty_q <= 1'b0;
      end

      if (fall) begin
        pos_q <= pos_next;
        ws_q  <= pos_next[5];
        sd_q  <= shift_q[63];
        if (pos_q == 6'd63) begin
          frame_start_q <= 1'b1;
          if (hold_empty_q) begin
            // A same-cycle accept only fills the holding register for the next frame.
            shift_q    <= empty_frame;
            underrun_q <= 1'b1;
            if (ucnt_q != 16'hFFFF) begin
              ucnt_q <= ucnt_q + 16'd1;
            end
          end else begin
            shift_q    <= hold_frame;
            consumed_q <= 1'b1;
          end
        end else begin
          shift_q <= {shift_q[62:0], 1'b0};
        end
      end
    end
  end

  assign s_ready        = hold_empty_q;
  assign i2s_clk        = bclk_q;
  assign i2s_ws         = ws_q;
  assign i2s_sd         = sd_q;
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
- REQ-001: Parameter CLK_DIV, default 4: system clocks per BCLK half-period; legal range is 2 or more.
- REQ-002: Parameter DATA_SIZE, default 24: sample width; legal range 1..32; slot width fixed at 32 bits.
- REQ-003: clk  input  1  system clock; sole clock domain.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: s_left  input  DATA_SIZE  left sample, two's complement.
- REQ-006: s_right  input  DATA_SIZE  right sample, two's complement.
- REQ-007: s_valid  input  1  sample pair valid.
- REQ-008: s_ready  output  1  holding register empty; transfer occurs when s_valid and s_ready are both high on a clk edge.
- REQ-009: i2s_clk  output  1  BCLK.
- REQ-010: i2s_ws  output  1  word select; 0 means left, 1 means right.
- REQ-011: i2s_sd  output  1  serial data.
- REQ-012: frame_start  output  1  one-cycle pulse when a frame is loaded.
- REQ-013: underrun  output  1  one-cycle pulse when a frame is loaded with an empty holding register.
- REQ-014: underrun_count  output  16  saturating underrun count.

Function
- REQ-015: The divider counts 0..CLK_DIV-1; i2s_clk toggles on the wrap; the first toggle after reset is 0->1, occurring CLK_DIV cycles after reset release.
- REQ-016: All frame events occur in the clk cycle in which i2s_clk goes 1->0 (a "fall"); i2s_ws and i2s_sd change only on falls; all outputs are registered.
- REQ-017: Bit position p (0..63) advances by 1 on each fall and wraps 63->0; the first fall after reset enters p=0.
- REQ-018: i2s_ws is 0 for p 0..31 and 1 for p 32..63 (Philips timing: WS leads data by one BCLK).
- REQ-019: Left slot occupies p 1..32; right slot occupies p 33..63 plus p=0 of the next frame; MSB first; slot bits below DATA_SIZE are 0.
- REQ-020: On the fall entering p=0, the holding pair loads into the frame shift register, the holding register empties, and frame_start pulses; i2s_sd at p=0 carries the previous frame's final right-slot bit.
- REQ-021: If the holding register is empty at the load, the frame is all zeros; underrun pulses; underrun_count increments, saturating at 0xFFFF.
- REQ-022: s_ready is high exactly when the holding register is empty; it rises in the cycle after frame_start.
- REQ-023: A transfer in the load cycle while the holding register is empty (no bypass) is not used by the current frame; that frame is an underrun and the new pair is held for the next frame.
- REQ-024: While the holding register is full, s_left and s_right are ignored.

Reset
- REQ-025: While rst_n is low, outputs and state take these values immediately: i2s_clk=0, i2s_ws=1, i2s_sd=0, s_ready=1, frame_start=0, underrun=0, underrun_count=0, p=63, divider=0, holding register empty, shift register zero.
- REQ-026: Reset mid-frame discards the holding register and the partial frame; no residual bits appear after reset release.

Configuration
- REQ-027: Macro I2S_TX_REPEAT_EN defined: on underrun, the last loaded pair is retransmitted instead of zeros (zeros if no pair has been loaded since reset); underrun and underrun_count behave as without the macro.
- REQ-028: Macro I2S_TX_REPEAT_EN undefined: underrun frames are all zeros.

Verification (CLK_DIV=2, DATA_SIZE=24)
- REQ-029: Release reset, no input -> i2s_clk rises at cycle 2 and first falls at cycle 4 with i2s_ws=0; frame_start and underrun pulse in that cycle; underrun_count=1.
- REQ-030: Pair L=0xA5A5A5, R=0x3C3C3C accepted before the first fall -> i2s_sd at p1..24 = A5A5A5 MSB first; p25..32 = 0; p33..56 = 3C3C3C; p57..63 and next p0 = 0; i2s_ws toggles at p=0 and p=32; no underrun.
- REQ-031: Three pairs offered back-to-back with s_valid held high -> s_ready drops after the first accept and rises the cycle after each frame_start; frames transmit in order; underrun_count stays 0.
- REQ-032: Data stops after pair 0x123456/0x654321 -> next frame all zeros with underrun; with I2S_TX_REPEAT_EN, the same pair repeats and underrun still pulses.
- REQ-033: rst_n pulsed low at p=40 with the holding register full -> reset values appear in the same cycle; the next frame after release is an underrun.
